// File: rtl/ahb_lite_mem.sv
// rtl/ahb_lite_mem.sv - AHB-Lite slave memory, single-port 32-bit-word RAM
//
// Purpose: reference AHB-Lite slave target. Each HADDR value selects one
// 32-bit word (word-indexed, no byte lanes). Fixed wait states are inserted
// on in-range transfers. Out-of-range addresses get a two-cycle ERROR.
//
// Ports:
//   HCLK     in   1   bus clock, rising-edge active
//   HRESETn  in   1   asynchronous reset, asserted when 1
//   HADDR    in   32  address-phase word index
//   HBURST   in   3   burst type (ignored)
//   HSEL     in   1   slave select
//   HSIZE    in   3   transfer size (ignored, always a full word)
//   HTRANS   in   2   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HWDATA   in   32  write data, data phase
//   HWRITE   in   1   1 = write, 0 = read
//   HRDATA   out  32  read data, valid when HREADY=1
//   HREADY   out  1   transfer done / bus ready
//   HRESP    out  1   0 = OKAY, 1 = ERROR
module ahb_lite_mem #(
  parameter int MEM_WORDS   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // The reset input is active-high despite its name.
  logic rst;
  assign rst = HRESETn;

  logic [31:0]   mem [MEM_WORDS];

  logic          valid_q;
  logic          write_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    wait_cnt;

  logic          accept;
  logic          in_range;
  logic          done_write;
  logic          fwd;
  logic [AW-1:0] haddr_idx;
  logic [31:0]   rd_word;
  logic          unused_ok;

  assign unused_ok  = ^{HBURST, HSIZE};

  assign accept     = HSEL && HREADY && HTRANS[1];
  assign in_range   = HADDR < 32'(MEM_WORDS);
  assign haddr_idx  = HADDR[AW-1:0];

  // A write data phase finishes on the edge where HREADY is high.
  assign done_write = HREADY && valid_q && write_q && !err_q;

  // A read accepted on the same edge that finishes a write to the same word
  // must see the new data, not the word still sitting in the array.
  assign fwd        = done_write && (addr_q == haddr_idx);
  assign rd_word    = fwd ? HWDATA : mem[haddr_idx];

  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      HREADY   <= 1'b1;
      HRESP    <= 1'b0;
      HRDATA   <= '0;
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wait_cnt <= '0;
    end else if (HREADY) begin
      // Ready edge: the current data phase ends and a new address may land.
      valid_q <= accept;
      if (accept) begin
        addr_q  <= haddr_idx;
        write_q <= HWRITE;
        err_q   <= !in_range;
        if (!in_range) begin
          // First ERROR cycle; wait states are never applied here.
          HREADY <= 1'b0;
          HRESP  <= 1'b1;
          HRDATA <= '0;
        end else if (WAIT_STATES == 0) begin
          HREADY <= 1'b1;
          HRESP  <= 1'b0;
          if (!HWRITE) begin
            HRDATA <= rd_word;
          end
        end else begin
          HREADY   <= 1'b0;
          HRESP    <= 1'b0;
          wait_cnt <= 4'(WAIT_STATES - 1);
        end
      end else begin
        HREADY <= 1'b1;
        HRESP  <= 1'b0;
      end
    end else begin
      // HREADY low: either the first ERROR cycle or a wait state.
      if (err_q) begin
        HREADY <= 1'b1;
      end else if (wait_cnt == 4'd0) begin
        HREADY <= 1'b1;
        if (!write_q) begin
          // Any earlier write already landed on the edge that accepted us.
          HRDATA <= mem[addr_q];
        end
      end else begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Memory contents survive reset; a write pending at reset is dropped.
  always_ff @(posedge HCLK) begin
    if (!rst && done_write) begin
      mem[addr_q] <= HWDATA;
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem.sv
// tb/tb_ahb_lite_mem.sv - self-checking bench for ahb_lite_mem
module tb_ahb_lite_mem;

  logic        HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        rst    = 1'b0;
  logic [31:0] haddr  = '0;
  logic [31:0] hwdata = '0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic        hsel0  = 1'b0;
  logic        hsel1  = 1'b0;
  logic [2:0]  hburst = 3'd0;
  logic [2:0]  hsize  = 3'd2;

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, resp0, resp1;

  ahb_lite_mem #(.MEM_WORDS(64), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(rst), .HADDR(haddr), .HBURST(hburst), .HSEL(hsel0),
    .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite),
    .HRDATA(rdata0), .HREADY(ready0), .HRESP(resp0)
  );

  ahb_lite_mem #(.MEM_WORDS(64), .WAIT_STATES(2)) u_dut1 (
    .HCLK(HCLK), .HRESETn(rst), .HADDR(haddr), .HBURST(hburst), .HSEL(hsel1),
    .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite),
    .HRDATA(rdata1), .HREADY(ready1), .HRESP(resp1)
  );

  int checks = 0;
  int errors = 0;
  int act    = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: each accepted transfer expands into a script of per-cycle responses.
  typedef struct {
    bit          rdy;
    bit          resp;
    bit          chk;
    logic [31:0] rdata;
    bit          wr;
    int          addr;
  } beat_t;

  beat_t       q[$];
  logic [31:0] mem_m [2][64];
  logic [31:0] last_rdata = '0;
  beat_t       e, b;
  bit          cur_rdy;
  int          nwait;

  always @(posedge HCLK) begin
    if (rst) begin
      q.delete();
      last_rdata = '0;
    end else begin
      cur_rdy = 1'b1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cur_rdy = e.rdy;
        if (e.chk) last_rdata = e.rdata;
        if (e.rdy && e.wr) mem_m[act][e.addr] = hwdata;
      end
      if (cur_rdy && ((act == 1) ? hsel1 : hsel0) && htrans[1]) begin
        if (haddr >= 32'd64) begin
          b.rdy = 0; b.resp = 1; b.chk = 1; b.rdata = '0; b.wr = 0; b.addr = 0;
          q.push_back(b);
          b.rdy = 1;
          q.push_back(b);
        end else begin
          nwait = (act == 1) ? 2 : 0;
          for (int i = 0; i < nwait; i++) begin
            b.rdy = 0; b.resp = 0; b.chk = 0; b.rdata = '0; b.wr = 0; b.addr = 0;
            q.push_back(b);
          end
          b.rdy   = 1;
          b.resp  = 0;
          b.chk   = !hwrite;
          b.rdata = hwrite ? 32'd0 : mem_m[act][haddr[5:0]];
          b.wr    = hwrite;
          b.addr  = int'(haddr[5:0]);
          q.push_back(b);
        end
      end
    end
  end

  // Compare process: one check set per cycle, away from the rising edge.
  logic        a_rdy, a_resp, x_rdy, x_resp, x_chk;
  logic [31:0] a_data, x_data;
  int          low_cnt = 0;

  always @(negedge HCLK) begin
    if (act == 1 && !ready1) low_cnt++;
    if (chk_en && !rst) begin
      a_rdy  = (act == 1) ? ready1 : ready0;
      a_resp = (act == 1) ? resp1  : resp0;
      a_data = (act == 1) ? rdata1 : rdata0;
      if (q.size() > 0) begin
        x_rdy = q[0].rdy; x_resp = q[0].resp; x_chk = q[0].chk; x_data = q[0].rdata;
      end else begin
        x_rdy = 1'b1; x_resp = 1'b0; x_chk = 1'b1; x_data = last_rdata;
      end
      check("hready", {31'd0, a_rdy}, {31'd0, x_rdy});
      check("hresp", {31'd0, a_resp}, {31'd0, x_resp});
      if (x_chk) check("hrdata", a_data, x_data);
    end
  end

  logic [31:0] seen_rdata;

  // One address phase (plus data-phase HWDATA for the previous transfer),
  // repeated until the slave is ready.
  task automatic cyc(input bit s, input logic [1:0] t, input bit w,
                     input int a, input logic [31:0] wd);
    bit r;
    haddr  = 32'(a);
    htrans = t;
    hwrite = w;
    hwdata = wd;
    if (act == 1) hsel1 = s; else hsel0 = s;
    for (int k = 0; k < 40; k++) begin
      @(negedge HCLK);
      r = (act == 1) ? ready1 : ready0;
      seen_rdata = (act == 1) ? rdata1 : rdata0;
      @(posedge HCLK);
      #1;
      if (r) return;
    end
    checks++;
    errors++;
    $display("FAIL cyc_timeout: HREADY stayed 0 for 40 cycles, expected 1");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_m[0][i] = '0;
      mem_m[1][i] = '0;
    end

    #1 rst = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("reset_hready", {31'd0, ready0}, 32'd1);
    check("reset_hresp", {31'd0, resp0}, 32'd0);
    check("reset_hrdata", rdata0, 32'd0);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(posedge HCLK);
    #1;

    // Pipelined sequence on the zero-wait instance.
    cyc(1, 2'd2, 0, 2, 32'd0);
    cyc(1, 2'd2, 1, 4, 32'd0);
    cyc(1, 2'd2, 1, 6, 32'd4);
    cyc(1, 2'd2, 0, 4, 32'd6);
    cyc(1, 2'd2, 0, 6, 32'd0);
    check("pipe_read4", seen_rdata, 32'd4);
    cyc(1, 2'd2, 0, 6, 32'd0);
    check("pipe_read6a", seen_rdata, 32'd6);
    cyc(1, 2'd0, 0, 0, 32'd0);
    check("pipe_read6b", seen_rdata, 32'd6);
    check("model_mem4", mem_m[0][4], 32'd4);
    check("model_mem6", mem_m[0][6], 32'd6);

    // Read-after-write forwarding.
    cyc(1, 2'd2, 1, 10, 32'd0);
    cyc(1, 2'd2, 0, 10, 32'hDEADBEEF);
    cyc(1, 2'd0, 0, 0, 32'd0);
    check("raw_forward", seen_rdata, 32'hDEADBEEF);

    // IDLE, BUSY and deselected writes must not touch memory.
    cyc(1, 2'd0, 1, 7, 32'd0);
    cyc(1, 2'd1, 1, 8, 32'h11);
    cyc(0, 2'd2, 1, 9, 32'h22);
    cyc(1, 2'd0, 0, 0, 32'h33);
    cyc(1, 2'd2, 0, 7, 32'd0);
    cyc(1, 2'd2, 0, 8, 32'd0);
    cyc(1, 2'd2, 0, 9, 32'd0);
    cyc(1, 2'd0, 0, 0, 32'd0);
    check("idle_no_write", seen_rdata, 32'd0);

    // Out-of-range write and read, then an in-range read of the aliased word.
    cyc(1, 2'd2, 1, 64, 32'd0);
    cyc(1, 2'd2, 0, 64, 32'hBAD0BAD0);
    cyc(1, 2'd2, 0, 0, 32'hBAD1BAD1);
    cyc(1, 2'd0, 0, 0, 32'd0);
    check("err_no_alias", seen_rdata, 32'd0);

    // Two-wait-state instance.
    act = 1;
    hsel0 = 1'b0;
    low_cnt = 0;
    cyc(1, 2'd2, 1, 3, 32'd0);
    cyc(1, 2'd2, 0, 3, 32'h55);
    cyc(1, 2'd0, 0, 0, 32'd0);
    check("wait_low_cycles", 32'(low_cnt), 32'd4);
    check("wait_read3", seen_rdata, 32'h55);

    // ERROR on the wait-state instance gets no extra wait cycles.
    cyc(1, 2'd2, 1, 100, 32'd0);
    cyc(1, 2'd0, 0, 0, 32'hAB);
    cyc(1, 2'd0, 0, 0, 32'd0);

    // Reset during a write data phase drops the write.
    cyc(1, 2'd2, 1, 5, 32'd0);
    htrans = 2'd0;
    hwdata = 32'h77;
    @(negedge HCLK);
    #2 rst = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("midreset_hready", {31'd0, ready1}, 32'd1);
    check("midreset_hrdata", rdata1, 32'd0);
    #2 rst = 1'b0;
    @(posedge HCLK);
    #1;
    cyc(1, 2'd2, 0, 5, 32'd0);
    cyc(1, 2'd0, 0, 0, 32'd0);
    check("midreset_no_write", seen_rdata, 32'd0);

    repeat (2) @(posedge HCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem.md
Name: ahb_lite_mem

Overview:
- Behavioural/synthesizable AHB-Lite slave memory: a single-port 32-bit-word RAM.
- Serves as a reference target for exercising the AHB-Lite master emulator and bus tasks.
- Each byte-address value of HADDR selects one 32-bit word, so every address is word-indexed; no byte lanes.
- Supports zero- or fixed-wait-state transfers and an ERROR response for out-of-range addresses.

Parameters:
- MEM_WORDS, 64: number of 32-bit words; valid addresses are 0..MEM_WORDS-1.
- WAIT_STATES, 0: number of HREADY-low cycles inserted in every valid data phase (0..15).

Ports:
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESETn  in  1  reset, asynchronous, active-high (asserted when 1), per block decision.
- HADDR  in  32  address-phase address; word index = HADDR value.
- HBURST  in  3  burst type; ignored, each beat is handled independently.
- HSEL  in  1  slave select.
- HSIZE  in  3  transfer size; ignored, every transfer is a full 32-bit word.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWDATA  in  32  write data, valid in the data phase.
- HWRITE  in  1  1 = write, 0 = read.
- HRDATA  out  32  read data, valid in the data phase when HREADY=1.
- HREADY  out  1  transfer done; also the bus-ready input sampled by this slave.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset values (async assert): HREADY=1, HRESP=0, HRDATA=0, no pending data phase, wait counter=0. Memory contents are not altered by reset; for simulation they are initialised to 0.
- Accept: a transfer is accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1. The edge registers addr_q, write_q, valid_q=1 and err_q=(HADDR>=MEM_WORDS).
- IDLE, BUSY, or HSEL=0 at a ready edge: valid_q=0. The next data phase is zero-wait OKAY with HREADY=1, HRESP=0, no memory access and HRDATA held.
- Valid in-range data phase, WAIT_STATES=0: HREADY=1 and HRESP=0 in the cycle after acceptance.
- Valid in-range data phase, WAIT_STATES=N: HREADY=0 for N cycles, then 1. New address phases are ignored while HREADY=0.
- Write: mem[addr_q] <= HWDATA on the edge that ends the data phase, i.e. the edge where HREADY=1.
- Read: HRDATA shows mem[addr_q] during the cycle in which HREADY=1.
  - Zero-wait: HRDATA is registered at the accept edge from mem[HADDR].
- Read-after-write hazard: a read address phase overlapping a write data phase to the same word returns the forwarded HWDATA, not the stale word.
- Back-to-back write then read at different addresses: both complete zero-wait with no bubble.
- Out-of-range address, two-cycle ERROR response:
  - Cycle 1: HREADY=0, HRESP=1.
  - Cycle 2: HREADY=1, HRESP=1.
  - Writes are suppressed; HRDATA is don't-care, driven 0.
  - WAIT_STATES is not applied before the ERROR response.
- Pipelining: the address phase of transfer N+1 overlaps the data phase of transfer N. The write data supplied in a given cycle belongs to the previously accepted address.
- Reset mid-transfer: the pending phase is dropped, outputs return to their reset values and no memory write occurs.

Test Plan:
- Reset held 2 cycles, then released -> HREADY=1, HRESP=0, HRDATA=0.
- Pipelined sequence, each line (addr, write, data-phase data): (2,R,-), (4,W,-), (6,W,4), (4,R,6), (6,R,-), (6,R,-).
  - Required: mem[4]=4 and mem[6]=6.
  - The read of 4 returns 4; both reads of 6 return 6.
  - HREADY stays 1 and HRESP stays 0 throughout.
- Read-after-write forwarding: write 0xDEADBEEF to word 10, with a read of word 10 in the overlapping address phase -> HRDATA=0xDEADBEEF.
- IDLE/BUSY or HSEL=0 with HWRITE=1 -> no memory change; OKAY zero-wait response.
- HADDR=MEM_WORDS (64): write, then read ->
  - Each gets the two-cycle ERROR sequence (HREADY 0→1, HRESP=1 in both cycles).
  - mem is unchanged; the following in-range transfer completes OKAY.
- WAIT_STATES=2, write 0x55 to word 3, then read word 3 -> each data phase holds HREADY=0 for exactly 2 cycles, and the read returns 0x55.
